// File: rtl/mandelbrot_wr_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : mandelbrot_wr_ctrl
// Brief    : Write-side sequencer that splits a frame into 4 KB-safe AXI bursts.
// Revision : 1.0
// ============================================================================
module mandelbrot_wr_ctrl #(
    parameter int C_ADDR_WIDTH      = 64,
    parameter int C_DATA_WIDTH      = 512,
    parameter int C_MAX_BURST_BEATS = 64,
    parameter int C_MAX_OUTSTANDING = 16
) (
    input  logic                      ap_clk,
    input  logic                      ap_rst_n,
    input  logic                      ap_start,
    output logic                      ap_idle,
    output logic                      ap_done,
    output logic                      wr_err,
    input  logic [C_ADDR_WIDTH-1:0]   ctrl_addr_offset,
    input  logic [31:0]               ctrl_length,
    input  logic                      s_tvalid,
    output logic                      s_tready,
    input  logic [C_DATA_WIDTH-1:0]   s_tdata,
    output logic                      m_axi_awvalid,
    input  logic                      m_axi_awready,
    output logic [C_ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic [7:0]                m_axi_awlen,
    output logic [2:0]                m_axi_awsize,
    output logic [1:0]                m_axi_awburst,
    output logic                      m_axi_wvalid,
    input  logic                      m_axi_wready,
    output logic [C_DATA_WIDTH-1:0]   m_axi_wdata,
    output logic [C_DATA_WIDTH/8-1:0] m_axi_wstrb,
    output logic                      m_axi_wlast,
    input  logic                      m_axi_bvalid,
    output logic                      m_axi_bready,
    input  logic [1:0]                m_axi_bresp
);
    localparam int c_STRB_W     = C_DATA_WIDTH / 8;
    localparam int c_BL         = $clog2(c_STRB_W);
    localparam int c_PAGE_BEATS = 4096 / c_STRB_W;
    localparam int c_OW         = $clog2(C_MAX_OUTSTANDING) + 1;
    localparam int c_FA         = $clog2(C_MAX_OUTSTANDING);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                  r_state, w_state_nxt;
    logic [C_ADDR_WIDTH-1:0] r_addr, r_awaddr;
    logic [26:0]             r_beats_left, r_w_left, w_len_beats;
    logic [c_BL-1:0]         r_tail;
    logic [c_OW-1:0]         r_outstanding, w_out_nxt, r_fcount;
    logic                    r_awvalid, r_wr_err;
    logic [7:0]              r_awlen, r_wbeat, w_head;
    logic [7:0]              r_fifo [C_MAX_OUTSTANDING];
    logic [c_FA-1:0]         r_wptr, r_rptr;
    logic [8:0]              w_page_room, w_n, w_hs_n;
    logic [c_STRB_W-1:0]     w_tail_mask;
    logic                    w_start, w_aw_hs, w_w_hs, w_fifo_ne, w_wlast, w_pop;
    logic                    w_unused_ok;

    assign w_unused_ok = &{1'b0, ctrl_addr_offset[c_BL-1:0]};

    assign w_start     = (r_state == S_IDLE) && ap_start;
    assign w_aw_hs     = r_awvalid && m_axi_awready;
    assign w_fifo_ne   = (r_fcount != '0);
    assign w_head      = r_fifo[r_rptr];
    assign w_wlast     = w_fifo_ne && (r_wbeat == w_head);
    assign w_w_hs      = s_tvalid && m_axi_wready && w_fifo_ne;
    assign w_pop       = w_w_hs && w_wlast;
    assign w_hs_n      = {1'b0, r_awlen} + 9'd1;
    assign w_len_beats = 27'(ctrl_length[31:c_BL]) + 27'(|ctrl_length[c_BL-1:0]);
    assign w_page_room = 9'(c_PAGE_BEATS) - 9'(r_addr[11:c_BL]);
    assign w_tail_mask = ~({c_STRB_W{1'b1}} << r_tail);

    always_comb begin
        w_n = 9'(C_MAX_BURST_BEATS);
        if (w_page_room < w_n)
            w_n = w_page_room;
        if (r_beats_left < 27'(w_n))
            w_n = 9'(r_beats_left);
    end

    always_comb begin
        w_out_nxt = r_outstanding;
        if (w_aw_hs && !m_axi_bvalid)
            w_out_nxt = r_outstanding + c_OW'(1);
        else if (!w_aw_hs && m_axi_bvalid)
            w_out_nxt = r_outstanding - c_OW'(1);
    end

    // Zero-length frames pass through DRAIN so done lands two cycles after start.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_start) w_state_nxt = (ctrl_length == 32'd0) ? S_DRAIN : S_RUN;
            S_RUN:   if (w_aw_hs && (r_beats_left == 27'(w_hs_n))) w_state_nxt = S_DRAIN;
            S_DRAIN: if ((w_out_nxt == '0) && !w_fifo_ne && (r_beats_left == '0))
                         w_state_nxt = S_DONE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_state       <= S_IDLE;
            r_addr        <= '0;
            r_beats_left  <= '0;
            r_w_left      <= '0;
            r_tail        <= '0;
            r_outstanding <= '0;
            r_awvalid     <= 1'b0;
            r_awaddr      <= '0;
            r_awlen       <= '0;
            r_wr_err      <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_outstanding <= w_out_nxt;
            if (w_start) begin
                r_addr       <= {ctrl_addr_offset[C_ADDR_WIDTH-1:c_BL], {c_BL{1'b0}}};
                r_beats_left <= w_len_beats;
                r_tail       <= ctrl_length[c_BL-1:0];
            end else if (w_aw_hs) begin
                r_addr       <= r_addr + (C_ADDR_WIDTH'(w_hs_n) << c_BL);
                r_beats_left <= r_beats_left - 27'(w_hs_n);
            end
            if (w_start)
                r_w_left <= w_len_beats;
            else if (w_w_hs)
                r_w_left <= r_w_left - 27'd1;
            if (w_aw_hs) begin
                r_awvalid <= 1'b0;
            end else if ((r_state == S_RUN) && !r_awvalid && (r_beats_left != '0) &&
                         (r_outstanding < c_OW'(C_MAX_OUTSTANDING))) begin
                r_awvalid <= 1'b1;
                r_awaddr  <= r_addr;
                r_awlen   <= 8'(w_n - 9'd1);
            end
            if (w_start)
                r_wr_err <= 1'b0;
            else if (m_axi_bvalid && (m_axi_bresp != 2'b00))
                r_wr_err <= 1'b1;
        end
    end

    // Burst-length FIFO: lets W beats run independently of the AW issue point.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_fcount <= '0;
            r_wbeat  <= '0;
        end else begin
            if (w_aw_hs)
                r_wptr <= r_wptr + c_FA'(1);
            if (w_pop)
                r_rptr <= r_rptr + c_FA'(1);
            if (w_aw_hs && !w_pop)
                r_fcount <= r_fcount + c_OW'(1);
            else if (!w_aw_hs && w_pop)
                r_fcount <= r_fcount - c_OW'(1);
            if (w_w_hs)
                r_wbeat <= w_wlast ? 8'd0 : r_wbeat + 8'd1;
        end
    end

    always_ff @(posedge ap_clk) begin
        if (w_aw_hs)
            r_fifo[r_wptr] <= r_awlen;
    end

    assign ap_idle       = (r_state == S_IDLE);
    assign ap_done       = (r_state == S_DONE);
    assign wr_err        = r_wr_err;
    assign m_axi_awvalid = r_awvalid;
    assign m_axi_awaddr  = r_awaddr;
    assign m_axi_awlen   = r_awlen;
    assign m_axi_awsize  = 3'(c_BL);
    assign m_axi_awburst = 2'b01;
    assign m_axi_wvalid  = s_tvalid && w_fifo_ne;
    assign s_tready      = m_axi_wready && w_fifo_ne;
    assign m_axi_wdata   = s_tdata;
    assign m_axi_wlast   = w_wlast;
    assign m_axi_wstrb   = !w_fifo_ne ? '0 :
                           ((r_w_left == 27'd1) && (r_tail != '0)) ? w_tail_mask : '1;
    assign m_axi_bready  = 1'b1;

endmodule
`default_nettype wire

// File: tb/tb_mandelbrot_wr_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_mandelbrot_wr_ctrl
// Brief    : Directed vector bench with a reactive AXI slave and stream source.
// Revision : 1.0
// ============================================================================
module tb_mandelbrot_wr_ctrl;
    logic         ap_clk = 1'b0;
    logic         ap_rst_n, ap_start, ap_idle, ap_done, wr_err;
    logic [63:0]  ctrl_addr_offset;
    logic [31:0]  ctrl_length;
    logic         s_tvalid, s_tready;
    logic [511:0] s_tdata, m_axi_wdata;
    logic         m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready, m_axi_wlast;
    logic [63:0]  m_axi_awaddr, m_axi_wstrb;
    logic [7:0]   m_axi_awlen;
    logic [2:0]   m_axi_awsize;
    logic [1:0]   m_axi_awburst, m_axi_bresp;
    logic         m_axi_bvalid, m_axi_bready;

    mandelbrot_wr_ctrl #(
        .C_ADDR_WIDTH(64), .C_DATA_WIDTH(512),
        .C_MAX_BURST_BEATS(64), .C_MAX_OUTSTANDING(2)
    ) dut (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ap_start(ap_start),
        .ap_idle(ap_idle), .ap_done(ap_done), .wr_err(wr_err),
        .ctrl_addr_offset(ctrl_addr_offset), .ctrl_length(ctrl_length),
        .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
        .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
        .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready), .m_axi_bresp(m_axi_bresp)
    );

    always #5 ap_clk = ~ap_clk;

    typedef struct {
        logic [63:0] base;
        logic [31:0] len;
        int          n_aw;
        logic [63:0] aw0_addr;
        logic [7:0]  aw0_len;
        logic [63:0] aw1_addr;
        logic [7:0]  aw1_len;
        int          n_beats;
        logic [63:0] last_strb;
        logic [63:0] wlast_mask;
    } vec_t;

    int n_pass = 0, n_total = 0;
    logic clr = 1'b0, stall = 1'b0, b_hold = 1'b0;
    int   err_burst = 0, src_total = 0;

    int cyc = 0, beat_cnt = 0, wlast_cnt = 0, strb_bad = 0, data_err = 0;
    int src_idx = 0, pending_b = 0, b_cnt = 0, last_b_cyc = -1, aw_unstable = 0;
    logic w_acc = 1'b0, aw_stall = 1'b0;
    logic [63:0] wlast_mask = '0, last_strb = '0, aw_p_addr = '0;
    logic [7:0]  aw_p_len = '0;
    logic [63:0] aw_addr_q[$];
    logic [7:0]  aw_len_q[$];
    int          aw_b_q[$];

    int first_aw_k, done_cnt, done_k, done_cyc;
    logic idle_after, idle_k1;

    function automatic logic [511:0] pat(input int idx);
        logic [511:0] d;
        for (int j = 0; j < 16; j++)
            d[j*32 +: 32] = (32'(idx) * 32'h9E3779B1) ^ 32'(j << 20);
        return d;
    endfunction

    // Slave-side monitor: every handshake is sampled on the rising edge.
    always @(posedge ap_clk) begin
        cyc <= cyc + 1;
        if (clr) begin
            aw_addr_q.delete(); aw_len_q.delete(); aw_b_q.delete();
            beat_cnt <= 0; wlast_cnt <= 0; strb_bad <= 0; data_err <= 0;
            src_idx <= 0; pending_b <= 0; b_cnt <= 0; last_b_cyc <= -1;
            aw_unstable <= 0; w_acc <= 1'b0; aw_stall <= 1'b0;
            wlast_mask <= '0; last_strb <= '0;
        end else begin
            w_acc   <= s_tvalid && s_tready;
            src_idx <= src_idx + int'(s_tvalid && s_tready);
            if (m_axi_wvalid && m_axi_wready) begin
                data_err <= data_err + int'(m_axi_wdata !== pat(beat_cnt))
                                     + int'(wlast_cnt >= aw_addr_q.size());
                strb_bad <= strb_bad + int'((beat_cnt != src_total - 1) && (m_axi_wstrb !== '1));
                last_strb <= m_axi_wstrb;
                if (m_axi_wlast && beat_cnt < 64)
                    wlast_mask <= wlast_mask | (64'd1 << beat_cnt);
                wlast_cnt <= wlast_cnt + int'(m_axi_wlast);
                beat_cnt  <= beat_cnt + 1;
            end
            if (m_axi_awvalid && m_axi_awready) begin
                aw_addr_q.push_back(m_axi_awaddr);
                aw_len_q.push_back(m_axi_awlen);
                aw_b_q.push_back(b_cnt);
            end
            if (aw_stall && (!m_axi_awvalid || m_axi_awaddr !== aw_p_addr || m_axi_awlen !== aw_p_len))
                aw_unstable <= aw_unstable + 1;
            aw_stall  <= m_axi_awvalid && !m_axi_awready;
            aw_p_addr <= m_axi_awaddr;
            aw_p_len  <= m_axi_awlen;
            pending_b <= pending_b + int'(m_axi_wvalid && m_axi_wready && m_axi_wlast)
                                   - int'(m_axi_bvalid);
            if (m_axi_bvalid) begin
                b_cnt      <= b_cnt + 1;
                last_b_cyc <= cyc;
            end
        end
    end

    // Slave ready/response and stream source drivers, updated on the falling edge.
    initial begin
        m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_bvalid = 1'b0; m_axi_bresp = 2'b00;
        s_tvalid = 1'b0; s_tdata = '0;
        forever begin
            @(negedge ap_clk);
            m_axi_awready = !stall || ($urandom_range(2) != 0);
            m_axi_wready  = !stall || ($urandom_range(2) != 0);
            if (clr || !ap_rst_n || src_idx >= src_total)
                s_tvalid = 1'b0;
            else if (!s_tvalid || w_acc)
                s_tvalid = !stall || ($urandom_range(3) != 0);
            s_tdata      = pat(src_idx);
            m_axi_bvalid = (pending_b > 0) && !b_hold && (!stall || ($urandom_range(1) == 1));
            m_axi_bresp  = (err_burst != 0 && b_cnt + 1 == err_burst) ? 2'b10 : 2'b00;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    endtask

    task automatic clear_logs();
        clr = 1'b1;
        @(negedge ap_clk);
        clr = 1'b0;
    endtask

    task automatic start_frame(input logic [63:0] base, input logic [31:0] len);
        ctrl_addr_offset = base;
        ctrl_length      = len;
        src_total        = int'(({32'd0, len} + 64'd63) >> 6);
        ap_start = 1'b1;
        @(negedge ap_clk);
        ap_start = 1'b0;
    endtask

    // Called on the falling edge just after start was sampled (observation k=1).
    task automatic wait_done(input int bound);
        int k = 1;
        bit seen = 0;
        done_cnt = 0; first_aw_k = -1; done_k = -1; done_cyc = -1; idle_after = 1'b0;
        idle_k1 = ap_idle;
        while (k <= bound) begin
            if (m_axi_awvalid && first_aw_k < 0) first_aw_k = k;
            if (ap_done) begin
                done_cnt++;
                if (!seen) begin seen = 1; done_k = k; done_cyc = cyc; end
            end else if (seen) begin
                idle_after = ap_idle;
                break;
            end
            @(negedge ap_clk);
            k++;
        end
        chk("done_seen", 64'(seen), 64'd1);
    endtask

    task automatic run_vec(input vec_t v);
        stall = 1'b0; b_hold = 1'b0; err_burst = 0;
        clear_logs();
        start_frame(v.base, v.len);
        wait_done(4000);
        chk("idle_falls", 64'(idle_k1), 64'd0);
        chk("n_aw", 64'(aw_addr_q.size()), 64'(v.n_aw));
        if (v.n_aw > 0) begin
            chk("aw0_addr", aw_addr_q[0], v.aw0_addr);
            chk("aw0_len", 64'(aw_len_q[0]), 64'(v.aw0_len));
            chk("aw_latency", 64'(first_aw_k), 64'd2);
            chk("done_after_b", 64'(done_cyc), 64'(last_b_cyc + 1));
        end else begin
            chk("no_awvalid", 64'(first_aw_k), 64'(-1));
            chk("zero_done_lat", 64'(done_k), 64'd2);
        end
        if (v.n_aw > 1) begin
            chk("aw1_addr", aw_addr_q[1], v.aw1_addr);
            chk("aw1_len", 64'(aw_len_q[1]), 64'(v.aw1_len));
        end
        chk("n_beats", 64'(beat_cnt), 64'(v.n_beats));
        chk("wlast_pos", wlast_mask, v.wlast_mask);
        if (v.n_beats > 0) chk("last_wstrb", last_strb, v.last_strb);
        chk("data_err", 64'(data_err), 64'd0);
        chk("full_strb", 64'(strb_bad), 64'd0);
        chk("done_once", 64'(done_cnt), 64'd1);
        chk("idle_after", 64'(idle_after), 64'd1);
        chk("wr_err", 64'(wr_err), 64'd0);
    endtask

    initial begin
        vec_t vt[6];
        vec_t vr;
        int k;
        vt[0] = '{64'h1000, 32'd4096, 1, 64'h1000, 8'd63, 64'h0, 8'd0, 64, '1, 64'h8000_0000_0000_0000};
        vt[1] = '{64'h2000, 32'd100,  1, 64'h2000, 8'd1,  64'h0, 8'd0, 2, 64'h0000_000F_FFFF_FFFF, 64'h2};
        vt[2] = '{64'h0FC0, 32'd256,  2, 64'h0FC0, 8'd0,  64'h1000, 8'd2, 4, '1, 64'h9};
        vt[3] = '{64'h3000, 32'd0,    0, 64'h0,    8'd0,  64'h0, 8'd0, 0, 64'h0, 64'h0};
        vt[4] = '{64'h2025, 32'd64,   1, 64'h2000, 8'd0,  64'h0, 8'd0, 1, '1, 64'h1};
        vt[5] = '{64'h1F80, 32'd200,  2, 64'h1F80, 8'd1,  64'h2000, 8'd1, 4, 64'hFF, 64'hA};
        vr    = '{64'h6000, 32'd64,   1, 64'h6000, 8'd0,  64'h0, 8'd0, 1, '1, 64'h1};

        ap_rst_n = 1'b1; ap_start = 1'b0; ctrl_addr_offset = '0; ctrl_length = '0;
        #1 ap_rst_n = 1'b0;
        #2;
        chk("rst_idle", 64'(ap_idle), 64'd1);
        chk("rst_done_err", 64'({ap_done, wr_err}), 64'd0);
        chk("rst_valids", 64'({m_axi_awvalid, m_axi_wvalid, m_axi_wlast, s_tready}), 64'd0);
        chk("rst_awaddr", m_axi_awaddr, 64'd0);
        chk("rst_awlen", 64'(m_axi_awlen), 64'd0);
        chk("rst_wstrb", m_axi_wstrb, 64'd0);
        chk("rst_consts", 64'({m_axi_bready, m_axi_awsize, m_axi_awburst}), 64'({1'b1, 3'd6, 2'b01}));
        repeat (3) @(negedge ap_clk);
        ap_rst_n = 1'b1;
        @(negedge ap_clk);

        for (int i = 0; i < 6; i++) run_vec(vt[i]);

        // Outstanding limit of 2, random stalls, B withheld, SLVERR on burst 2.
        clear_logs();
        stall = 1'b1; b_hold = 1'b1; err_burst = 2;
        start_frame(64'h10000, 32'd12288);
        k = 0;
        while (aw_addr_q.size() < 2 && k < 2000) begin @(negedge ap_clk); k++; end
        repeat (600) @(negedge ap_clk);
        chk("aw_held_by_limit", 64'(aw_addr_q.size()), 64'd2);
        chk("beats_before_b", 64'(beat_cnt), 64'd128);
        b_hold = 1'b0;
        wait_done(6000);
        chk("bp_n_aw", 64'(aw_addr_q.size()), 64'd3);
        chk("bp_aw2_addr", aw_addr_q[2], 64'h12000);
        chk("bp_aw2_len", 64'(aw_len_q[2]), 64'd63);
        chk("bp_aw1_addr", aw_addr_q[1], 64'h11000);
        chk("bp_aw3_after_b", 64'(aw_b_q[2] >= 1), 64'd1);
        chk("bp_beats", 64'(beat_cnt), 64'd192);
        chk("bp_wlast_cnt", 64'(wlast_cnt), 64'd3);
        chk("bp_data_err", 64'(data_err), 64'd0);
        chk("bp_aw_stable", 64'(aw_unstable), 64'd0);
        chk("bp_done_once", 64'(done_cnt), 64'd1);
        repeat (3) @(negedge ap_clk);
        chk("bp_wr_err_sticky", 64'(wr_err), 64'd1);
        chk("bp_idle", 64'(ap_idle), 64'd1);
        stall = 1'b0; err_burst = 0;
        run_vec(vt[4]);

        // Asynchronous reset in the middle of a burst.
        clear_logs();
        b_hold = 1'b1;
        start_frame(64'h4000, 32'd4096);
        repeat (12) @(negedge ap_clk);
        chk("mid_burst_flowing", 64'(s_tready), 64'd1);
        #2 ap_rst_n = 1'b0;
        #1;
        chk("mrst_idle_done", 64'({ap_idle, ap_done, wr_err}), 64'({1'b1, 1'b0, 1'b0}));
        chk("mrst_valids", 64'({m_axi_awvalid, m_axi_wvalid, m_axi_wlast, s_tready}), 64'd0);
        chk("mrst_aw", 64'({m_axi_awaddr[55:0], m_axi_awlen}), 64'd0);
        chk("mrst_wstrb", m_axi_wstrb, 64'd0);
        src_total = 0; b_hold = 1'b0;
        @(negedge ap_clk);
        clear_logs();
        ap_rst_n = 1'b1;
        @(negedge ap_clk);
        run_vec(vr);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
`default_nettype wire
